// File: rtl/func_sweep_ctrl_if.sv
// Signal bundle between the truth-table sweep controller and its environment.
// master = sweep controller side, slave = stimulus / function-under-test side.
interface func_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic        f_in;
  logic        a, b, c, d;
  logic        busy;
  logic        done;
  logic [15:0] tbl;
  logic [4:0]  ones;
  logic        pass;

  modport master (
    input  start, abort, expected, f_in,
    output a, b, c, d, busy, done, tbl, ones, pass
  );

  modport slave (
    output start, abort, expected, f_in,
    input  a, b, c, d, busy, done, tbl, ones, pass
  );
endinterface

// File: rtl/func_sweep_ctrl.sv
// Sweeps all 16 input vectors of a 4-input function, captures its truth table
// and compares it against a golden table latched when the sweep starts.
module func_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  func_sweep_ctrl_if.master   bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [15:0] exp_q;
  logic [15:0] tbl_q;
  logic [4:0]  ones_q;
  logic        pass_q;
  logic        busy_q;
  logic        done_q;

  assign {bus.a, bus.b, bus.c, bus.d} = idx;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tbl  = tbl_q;
  assign bus.ones = ones_q;
  assign bus.pass = pass_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      exp_q  <= '0;
      tbl_q  <= '0;
      ones_q <= '0;
      pass_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // abort wins over a simultaneous start
          if (bus.start && !bus.abort) begin
            exp_q  <= bus.expected;
            tbl_q  <= '0;
            ones_q <= '0;
            pass_q <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= DRIVE;
          end
        end
        DRIVE, SAMPLE: begin
          if (bus.abort) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            tbl_q  <= '0;
            ones_q <= '0;
            pass_q <= 1'b0;
            busy_q <= 1'b0;
          end else if (state == DRIVE) begin
            if (cnt == 4'(SETTLE - 1)) begin
              cnt   <= '0;
              state <= SAMPLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else begin
            tbl_q[idx] <= bus.f_in;
            ones_q     <= ones_q + {4'b0, bus.f_in};
            if (idx == 4'd15) begin
              // last bit is being written this edge, so compare with it folded in
              pass_q <= ({bus.f_in, tbl_q[14:0]} == exp_q);
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= DRIVE;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          idx    <= '0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/func_sweep_ctrl.md
FUNC_SWEEP_CTRL -- requirements
Module: func_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the cycles each input vector is driven before f_in is sampled (legal range 1..15).
REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
  clk  input  1  single clock; all state changes on rising edge
  rst  input  1  asynchronous, active-high reset
  start  input  1  request a full 16-vector sweep
  abort  input  1  cancel a sweep in progress
  expected  input  16  golden truth table; bit i = expected f for vector i
  f_in  input  1  response of the 4-input function under test
  a, b, c, d  output  1 each  drive the function under test; {a,b,c,d} = vector index, a = MSB
  busy  output  1  high while a sweep is in progress
  done  output  1  one-cycle pulse at sweep completion
  tbl  output  16  captured truth table; bit i = sampled f_in for vector i
  ones  output  5  count of 1s captured (0..16)
  pass  output  1  tbl equals latched expected
REQ-003 Reset SHALL be asynchronous and active-high on rst; clk SHALL be the only clock.

Function
REQ-004 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-005 In IDLE, start=1 at an edge SHALL latch expected, clear tbl, ones and pass, set idx=0 and move to DRIVE.
REQ-006 In DRIVE, {a,b,c,d} SHALL equal idx for exactly SETTLE cycles, then the FSM SHALL move to SAMPLE.
REQ-007 In SAMPLE, the FSM SHALL write tbl[idx]<=f_in and ones<=ones+f_in, keeping {a,b,c,d}=idx.
REQ-008 From SAMPLE, idx<15 SHALL increment idx and return to DRIVE; idx==15 SHALL go to DONE with no wrap or increment.
REQ-009 In DONE, done SHALL be high for exactly that one cycle, pass SHALL be set to (tbl==latched expected), and the FSM SHALL return to IDLE.
REQ-010 Latency: done SHALL assert in the cycle beginning 16*(SETTLE+1) edges after the edge that accepted start; with SETTLE=1 that is 32 edges.
REQ-011 busy SHALL be high in DRIVE, SAMPLE and DONE, and low in IDLE.
REQ-012 tbl, ones and pass SHALL hold their values in IDLE until the next accepted start.
REQ-013 start while busy SHALL be ignored, and no sweep SHALL be queued.
REQ-014 abort=1 in DRIVE or SAMPLE SHALL return the FSM to IDLE at the next edge with no done pulse, clearing tbl, ones and pass to 0 and {a,b,c,d} to 0.
REQ-015 abort in DONE SHALL be ignored, so the sweep completes normally.
REQ-016 start and abort both high in IDLE SHALL leave the FSM in IDLE, since abort has priority.
REQ-017 Changes to expected after start is accepted SHALL NOT affect pass.
REQ-018 In IDLE, {a,b,c,d} SHALL be 0.
REQ-019 The ones counter SHALL be 5 bits and SHALL reach 16 without overflow.

Reset
REQ-020 While rst=1, and immediately on its assertion regardless of clk, the block SHALL set state=IDLE, idx=0, and a, b, c, d, busy, done, tbl, ones and pass to 0.
REQ-021 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.
REQ-022 After rst deasserts, the first start seen high at an edge SHALL begin a sweep.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
  V1: f_in = ~a&~d&(b|c), expected=16'h0054, SETTLE=1, start pulse -> done 32 edges later; tbl=16'h0054, ones=3, pass=1.
  V2: same function, expected=16'h0055 -> tbl=16'h0054, ones=3, pass=0.
  V3: f_in tied to 1, expected=16'hFFFF -> ones=16, pass=1; f_in tied to 0 -> tbl=0, ones=0.
  V4: abort pulsed while idx=7 -> busy low next edge, no done, tbl=0, ones=0, pass=0; a following start runs a full sweep.
  V5: start re-pulsed at idx=3 during a sweep -> ignored, single done; start+abort together in IDLE -> stays IDLE.
  V6: rst asserted between clk edges mid-sweep -> all outputs 0 immediately; SETTLE=3 run -> done at 64 edges, each vector held 3 cycles before its sample.
